// File: rtl/mux_dp_pkg.sv
// Shared types and defaults for the mux_dp_pipe registered multiplexer.
package mux_dp_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int MUX_DP_DEF_W = 32;
  localparam int MUX_DP_DEF_N = 4;

endpackage

// File: rtl/mux_dp_sel.sv
// Combinational N:1 channel select with out-of-range detection.
// Out-of-range selects yield a zero word.
module mux_dp_sel
  import mux_dp_pkg::*;
#(
  parameter int W  = MUX_DP_DEF_W,
  parameter int N  = MUX_DP_DEF_N,
  parameter int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   word,
  output logic           oor
);

  always_comb begin
    word = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) word = din[k*W +: W];
    end
  end

  // Only a non-power-of-two channel count leaves select codes unused.
  generate
    if ((1 << SW) > N) begin : g_range
      assign oor = (sel >= SW'(N));
    end else begin : g_full
      assign oor = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mux_dp_pipe.sv
// Registered N-way datapath mux with valid/ready and a two-entry skid buffer.
// Optional sticky range error flag enabled by defining MUX_DP_RANGE_CHK_EN.
module mux_dp_pipe
  import mux_dp_pkg::*;
#(
  parameter int W = MUX_DP_DEF_W,
  parameter int N = MUX_DP_DEF_N,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  sel_q,
  output logic           err
);

  occ_e          state_q, state_d;
  logic [W-1:0]  main_q, main_d;
  logic [SW-1:0] main_sel_q, main_sel_d;
  logic [W-1:0]  skid_q, skid_d;
  logic [SW-1:0] skid_sel_q, skid_sel_d;

  logic [W-1:0]  word;
  logic          oor;
  logic          push;
  logic          pop;

  mux_dp_sel #(.W(W), .N(N), .SW(SW)) u_sel (
    .sel  (sel),
    .din  (din),
    .word (word),
    .oor  (oor)
  );

  // Handshake decodes come from registered state only.
  assign in_ready  = (state_q != OCC_TWO);
  assign out_valid = (state_q != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dout      = main_q;
  assign sel_q     = main_sel_q;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_sel_d = main_sel_q;
    skid_d     = skid_q;
    skid_sel_d = skid_sel_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          main_d     = word;
          main_sel_d = sel;
          state_d    = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          main_d     = word;
          main_sel_d = sel;
        end else if (push) begin
          skid_d     = word;
          skid_sel_d = sel;
          state_d    = OCC_TWO;
        end else if (pop) begin
          state_d    = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          main_d     = skid_q;
          main_sel_d = skid_sel_q;
          state_d    = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      main_q     <= '0;
      main_sel_q <= '0;
      skid_q     <= '0;
      skid_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_sel_q <= main_sel_d;
      skid_q     <= skid_d;
      skid_sel_q <= skid_sel_d;
    end
  end

`ifdef MUX_DP_RANGE_CHK_EN
  logic err_q, err_d;

  always_comb err_d = err_q | (push && oor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_oor;
  assign unused_oor = oor;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mux_dp_pipe.sv
// Directed bench for mux_dp_pipe: a 4-channel and a 3-channel instance.
module tb_mux_dp_pipe;

  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0]  sel, sel_q;
  logic [127:0] din;
  logic [31:0] dout;

  logic        in3_valid, in3_ready, out3_valid, out3_ready, err3;
  logic [1:0]  sel3, sel3_q;
  logic [95:0] din3;
  logic [31:0] dout3;

  int errors = 0;
  int checks = 0;

`ifdef MUX_DP_RANGE_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  mux_dp_pipe #(.W(32), .N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .din(din),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .sel_q(sel_q), .err(err)
  );

  mux_dp_pipe #(.W(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in3_valid), .in_ready(in3_ready),
    .sel(sel3), .din(din3),
    .out_valid(out3_valid), .out_ready(out3_ready),
    .dout(dout3), .sel_q(sel3_q), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    logic [31:0] exp_w;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    sel        = '0;
    din        = '0;
    in3_valid  = 1'b0;
    out3_ready = 1'b1;
    sel3       = '0;
    din3       = '0;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_sel_q", 64'(sel_q), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err3", 64'(err3), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single beat, latency 1
    sel      = 2'd2;
    din      = pack4(32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_dout", 64'(dout), 64'hDEADBEEF);
    chk("single_sel_q", 64'(sel_q), 64'd2);
    tick();
    chk("single_drain_valid", 64'(out_valid), 64'd0);
    chk("single_hold_dout", 64'(dout), 64'hDEADBEEF);

    // Streaming at one beat per clock
    for (int i = 0; i < 8; i++) begin
      sel      = 2'(i % 4);
      din      = pack4(32'h10000000 + 32'(i*16) + 0, 32'h10000000 + 32'(i*16) + 1,
                       32'h10000000 + 32'(i*16) + 2, 32'h10000000 + 32'(i*16) + 3);
      in_valid = 1'b1;
      chk($sformatf("stream_in_ready_%0d", i), 64'(in_ready), 64'd1);
      tick();
      exp_w = 32'h10000000 + 32'(i*16) + 32'(i % 4);
      chk($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream_dout_%0d", i), 64'(dout), 64'(exp_w));
      chk($sformatf("stream_sel_q_%0d", i), 64'(sel_q), 64'(i % 4));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: A, B accepted, C stalled
    out_ready = 1'b0;
    sel = 2'd1; din = pack4(32'h0, 32'hAAAA0001, 32'h0, 32'h0); in_valid = 1'b1;
    tick();
    chk("bp_A_dout", 64'(dout), 64'hAAAA0001);
    chk("bp_in_ready_one", 64'(in_ready), 64'd1);
    sel = 2'd3; din = pack4(32'h0, 32'h0, 32'h0, 32'hBBBB0003);
    tick();
    chk("bp_in_ready_two", 64'(in_ready), 64'd0);
    chk("bp_hold_A", 64'(dout), 64'hAAAA0001);
    sel = 2'd0; din = pack4(32'hCCCC0000, 32'h0, 32'h0, 32'h0);
    tick();
    chk("bp_C_stalled_ready", 64'(in_ready), 64'd0);
    chk("bp_C_stalled_dout", 64'(dout), 64'hAAAA0001);
    chk("bp_C_stalled_sel_q", 64'(sel_q), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_B_dout", 64'(dout), 64'hBBBB0003);
    chk("bp_B_sel_q", 64'(sel_q), 64'd3);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pushpop_valid", 64'(out_valid), 64'd1);
    chk("bp_C_dout", 64'(dout), 64'hCCCC0000);
    chk("bp_C_sel_q", 64'(sel_q), 64'd0);
    tick();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);

    // Out-of-range select on the 3-channel instance
    sel3 = 2'd3; din3 = {32'h33333333, 32'h22222222, 32'h11111111}; in3_valid = 1'b1;
    tick();
    chk("oor_valid", 64'(out3_valid), 64'd1);
    chk("oor_dout", 64'(dout3), 64'd0);
    chk("oor_sel_q", 64'(sel3_q), 64'd3);
    chk("oor_err", 64'(err3), 64'(EXP_ERR));
    sel3 = 2'd1;
    tick();
    in3_valid = 1'b0;
    chk("legal3_dout", 64'(dout3), 64'h22222222);
    chk("legal3_err_sticky", 64'(err3), 64'(EXP_ERR));
    tick();
    chk("legal3_err_still", 64'(err3), 64'(EXP_ERR));
    chk("n4_err_clear", 64'(err), 64'd0);

    // Asynchronous reset while holding two beats
    out_ready = 1'b0;
    sel = 2'd0; din = pack4(32'h5A5A5A5A, 32'h0, 32'h0, 32'h0); in_valid = 1'b1;
    tick();
    sel = 2'd1; din = pack4(32'h0, 32'hA5A5A5A5, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("two_before_rst", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_dout", 64'(dout), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_err3", 64'(err3), 64'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_no_replay_0", 64'(out_valid), 64'd0);
    tick();
    chk("arst_no_replay_1", 64'(out_valid), 64'd0);
    chk("arst_dout_zero", 64'(dout), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
